// File: rtl/catch_light_scheduler.sv
// Catch the Light round controller: paced LED events, catch-window judging,
// saturating score and game-over flag.
module catch_light_scheduler #(
  parameter int         NUM_LEDS = 8,
  parameter int         PERIOD0  = 268435455,
  parameter int         PERIOD1  = 134217727,
  parameter int         PERIOD2  = 67108863,
  parameter int         WINDOW   = 50000000,
  parameter int         ROUNDS   = 21,
  parameter logic [7:0] SEED     = 8'h01
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_LEDS-1:0] btn,
  output logic [NUM_LEDS-1:0] led,
  output logic                turn_on,
  output logic                hit,
  output logic                miss,
  output logic [5:0]          score,
  output logic [5:0]          round,
  output logic                busy,
  output logic                game_over
);

  localparam int IDX_W = $clog2(NUM_LEDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GAP  = 2'd1;
  localparam logic [1:0] LIT  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [27:0] GAP0_LAST = 28'(PERIOD0 - 1);
  localparam logic [27:0] GAP1_LAST = 28'(PERIOD1 - 1);
  localparam logic [27:0] GAP2_LAST = 28'(PERIOD2 - 1);
  localparam logic [27:0] WIN_LAST  = 28'(WINDOW - 1);
  localparam logic [5:0]  LAST_RND  = 6'(ROUNDS);

  logic [1:0]          state;
  logic [27:0]         timer;
  logic [7:0]          lfsr;
  logic                lfsr_fb;
  logic [NUM_LEDS-1:0] btn_prev;
  logic [NUM_LEDS-1:0] rise;
  logic [NUM_LEDS-1:0] next_led;
  logic [27:0]         gap_last;
  logic                hit_now;
  logic                wrong_now;
  logic                timeout_now;
  logic                resolve;

  always_comb begin
    rise        = btn & ~btn_prev;
    hit_now     = |(rise & led);
    wrong_now   = |(rise & ~led);
    // a rise in the final window cycle still decides the outcome
    timeout_now = (timer == WIN_LAST) && !(|rise);
    resolve     = hit_now | wrong_now | timeout_now;
    lfsr_fb     = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    next_led    = '0;
    next_led[lfsr[IDX_W-1:0]] = 1'b1;
    if (round < 6'd6)       gap_last = GAP0_LAST;
    else if (round < 6'd11) gap_last = GAP1_LAST;
    else                    gap_last = GAP2_LAST;
  end

  assign busy = (state == GAP) || (state == LIT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      timer     <= '0;
      lfsr      <= SEED;
      btn_prev  <= '0;
      led       <= '0;
      turn_on   <= 1'b0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      score     <= '0;
      round     <= '0;
      game_over <= 1'b0;
    end else begin
      btn_prev <= btn;
      turn_on  <= 1'b0;
      hit      <= 1'b0;
      miss     <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            score     <= '0;
            round     <= '0;
            game_over <= 1'b0;
            timer     <= '0;
            state     <= GAP;
          end
        end
        GAP: begin
          if (timer == gap_last) begin
            led     <= next_led;
            lfsr    <= {lfsr[6:0], lfsr_fb};
            turn_on <= 1'b1;
            round   <= round + 6'd1;
            timer   <= '0;
            state   <= LIT;
          end else begin
            timer <= timer + 28'd1;
          end
        end
        LIT: begin
          if (resolve) begin
            hit   <= hit_now;
            miss  <= !hit_now;
            led   <= '0;
            timer <= '0;
            if (hit_now && score != 6'd63) score <= score + 6'd1;
            if (round == LAST_RND) begin
              game_over <= 1'b1;
              state     <= DONE;
            end else begin
              state <= GAP;
            end
          end else begin
            timer <= timer + 28'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
